spike_event_fifo: RTL and testbench
===================================

Name: spike_event_fifo

Overview:
- Downstream consumer of the LIF neuron's spike output.
- Timestamps every spike against a step counter that advances on each membrane-update cycle, then buffers the timestamps in a small FIFO.
- The FIFO is drained one byte at a time over a valid/ready handshake, so spike trains can be read out through the 8-bit output pins without losing ordering.
- Also reports overflow, a saturating drop count and the live step counter.

Parameters:
- TS_BITS, 8, timestamp / step-counter width; must be ≤8 (rd_data is 8 bits, zero-extended above TS_BITS).
- DEPTH_LOG2, 2, FIFO depth = 2**DEPTH_LOG2 entries (default 4).
- DROP_BITS, 4, width of the saturating dropped-event counter.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-high reset.
- step, input, 1, membrane-update strobe (high on cycles the neuron commits last_membrane).
- spike, input, 1, neuron spike flag; sampled only when step=1.
- rd_ready, input, 1, consumer accepts head entry this cycle.
- clear_status, input, 1, clears overflow and drop_count.
- rd_data, output, 8, head timestamp, zero-extended; 0 when empty.
- rd_valid, output, 1, FIFO non-empty.
- full, output, 1, FIFO holds 2**DEPTH_LOG2 entries.
- overflow, output, 1, sticky: a spike was dropped.
- drop_count, output, DROP_BITS, saturating count of dropped spikes.
- step_count, output, TS_BITS, current step counter.

Behaviour:
- Reset (sync, high): step_count=0, FIFO empty (rd_ptr=wr_ptr=0, count=0), rd_valid=0, full=0, rd_data=0, overflow=0, drop_count=0; reset overrides every other input in the same cycle.
- Step counter: on step=1, step_count <= step_count+1, wrapping modulo 2**TS_BITS (255 -> 0 at default).
- Push: condition is step=1 & spike=1; value stored is step_count before the increment.
- Push visibility: a pushed entry is visible on rd_data/rd_valid the cycle after the push edge (1-cycle latency).
- Pop: on rd_valid=1 & rd_ready=1, the head is removed at the edge; rd_ready while empty is ignored.
- Full, no pop in same cycle: push is dropped, overflow <= 1, drop_count increments and saturates at 2**DROP_BITS-1.
- Full, pop in same cycle: push is accepted; count unchanged, pointers both advance.
- Empty, rd_ready in same cycle as a push: push accepted, no pop; count becomes 1.
- clear_status=1 with a simultaneous drop: the drop wins (overflow=1, drop_count=1).
- Storage and flags:
  - Pointers are DEPTH_LOG2 bits and wrap naturally.
  - count is DEPTH_LOG2+1 bits.
  - full = (count == 2**DEPTH_LOG2); rd_valid = (count != 0).
  - Storage is a register array; rd_data is driven combinationally from mem[rd_ptr] gated by rd_valid.
- Ordering is strictly FIFO.
- step with spike=0 only advances the counter.
- spike without step is ignored.

Optional Feature:
- Macro: SPIKE_RATE_EN.
- Defined: adds output rate [7:0] and parameter WIN_LOG2 (default 4).
  - A window counter counts step strobes; a spike accumulator counts step&spike, saturating at 255.
  - When the window counter wraps after 2**WIN_LOG2 steps, rate latches the accumulator, including the spike of the closing step.
  - The accumulator then restarts at 0.
  - Reset clears all three registers.
- Not defined: no rate port, no extra registers; FIFO behaviour is identical.

Test Plan:
- Reset, then 3 step pulses with spike=1,0,1 -> FIFO holds 0,2; step_count=3; rd_valid=1 one cycle after first push, rd_data=0.
- Pop with rd_ready=1 for 2 cycles after the above -> rd_data 0 then 2, then rd_valid=0, rd_data=0.
- 6 consecutive step&spike at step_count 10..15 with rd_ready=0 -> FIFO 10,11,12,13; full=1; overflow=1; drop_count=2.
- FIFO full plus simultaneous push and pop -> head popped, new timestamp appended, full stays 1, overflow unchanged.
- 256 steps without spikes, then step&spike -> stored timestamp 0 (wrap); reset asserted mid-sequence with 2 entries -> next cycle rd_valid=0, step_count=0, overflow=0.
- SPIKE_RATE_EN, WIN_LOG2=4: 16 steps with spike on every other step -> rate=8 after the 16th step; the next window with no spikes -> rate=0.

Source files
------------

// File: rtl/spike_event_fifo_if.sv
// spike_event_fifo_if
// Read-side handshake bundle of the spike event FIFO.
//   rd_data  : head timestamp, zero-extended to 8 bits, 0 when the FIFO is empty
//   rd_valid : FIFO holds at least one entry
//   rd_ready : consumer takes the head entry on this clock edge
// Modports:
//   master : FIFO side (drives rd_data / rd_valid, samples rd_ready)
//   slave  : consumer side (samples rd_data / rd_valid, drives rd_ready)
interface spike_event_fifo_if;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;

    modport master (
        output rd_data,
        output rd_valid,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        output rd_ready
    );
endinterface

// File: rtl/spike_event_fifo.sv
// spike_event_fifo
// Timestamps LIF neuron spikes against a step counter that advances on every
// membrane-update strobe, and queues the timestamps in a small FIFO. The FIFO
// is read one 8-bit entry at a time through a valid/ready handshake.
//
// Ports:
//   clk          : clock, all state changes on the rising edge
//   reset        : synchronous active-high reset, overrides every other input
//   step         : membrane-update strobe
//   spike        : neuron spike flag, only looked at while step=1
//   clear_status : clears overflow and drop_count (a same-cycle drop wins)
//   rd           : read handshake (spike_event_fifo_if.master)
//   full         : FIFO holds 2**DEPTH_LOG2 entries
//   overflow     : sticky, at least one spike was dropped
//   drop_count   : saturating count of dropped spikes
//   step_count   : live step counter
//   rate         : spikes counted in the last closed window
//                  (only when SPIKE_RATE_EN is defined)
//
// Optional feature macro: SPIKE_RATE_EN
//   When defined, adds parameter WIN_LOG2 and output rate[7:0]. A window of
//   2**WIN_LOG2 step strobes is counted; the spikes seen inside it (saturating
//   at 255) are latched into rate when the window closes.
module spike_event_fifo #(
    parameter int TS_BITS    = 8,
    parameter int DEPTH_LOG2 = 2,
    parameter int DROP_BITS  = 4
`ifdef SPIKE_RATE_EN
    ,
    parameter int WIN_LOG2   = 4
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step,
    input  logic                  spike,
    input  logic                  clear_status,
    spike_event_fifo_if.master    rd,
    output logic                  full,
    output logic                  overflow,
    output logic [DROP_BITS-1:0]  drop_count,
    output logic [TS_BITS-1:0]    step_count
`ifdef SPIKE_RATE_EN
    ,
    output logic [7:0]            rate
`endif
);

    localparam int                    DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
    localparam logic [TS_BITS-1:0]    TS_ONE    = 1;
    localparam logic [DROP_BITS-1:0]  DROP_ONE  = 1;
    localparam logic [DROP_BITS-1:0]  DROP_MAX  = '1;

    logic [TS_BITS-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  valid_int;
    logic                  push_req;
    logic                  pop;
    logic                  push_ok;
    logic                  drop;
    logic [7:0]            rd_data_ext;

    assign valid_int = (count != '0);
    assign full      = (count == DEPTH_CNT);
    assign push_req  = step & spike;
    assign pop       = valid_int & rd.rd_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok   = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    always_comb begin
        count_next = count;
        if (push_ok && !pop) begin
            count_next = count + CNT_ONE;
        end else if (pop && !push_ok) begin
            count_next = count - CNT_ONE;
        end
    end

    always_comb begin
        rd_data_ext = '0;
        if (valid_int) begin
            rd_data_ext[TS_BITS-1:0] = mem[rd_ptr];
        end
    end

    assign rd.rd_data  = rd_data_ext;
    assign rd.rd_valid = valid_int;

    always_ff @(posedge clk) begin
        if (reset) begin
            step_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            if (step) begin
                step_count <= step_count + TS_ONE;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
        end
    end

    // When full with a simultaneous pop, wr_ptr equals rd_ptr: the slot being
    // overwritten is the head that is leaving on this same edge.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr] <= step_count;
        end
    end

    // A drop in the same cycle as clear_status leaves exactly that one drop
    // recorded.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_status) begin
                drop_count <= DROP_ONE;
            end else if (drop_count != DROP_MAX) begin
                drop_count <= drop_count + DROP_ONE;
            end
        end else if (clear_status) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

`ifdef SPIKE_RATE_EN
    localparam logic [WIN_LOG2-1:0] WIN_ONE = 1;
    localparam logic [WIN_LOG2-1:0] WIN_END = '1;

    logic [WIN_LOG2-1:0] win_count;
    logic [7:0]          spike_acc;
    logic [7:0]          spike_acc_next;

    // Accumulator value including the current step's spike, so the step that
    // closes a window is still counted in that window.
    always_comb begin
        spike_acc_next = spike_acc;
        if (push_req && spike_acc != 8'hFF) begin
            spike_acc_next = spike_acc + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_count <= '0;
            spike_acc <= '0;
            rate      <= '0;
        end else if (step) begin
            win_count <= win_count + WIN_ONE;
            if (win_count == WIN_END) begin
                rate      <= spike_acc_next;
                spike_acc <= '0;
            end else begin
                spike_acc <= spike_acc_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spike_event_fifo.sv
// tb_spike_event_fifo
// Directed bench for spike_event_fifo. The stimulus process queues the
// hand-computed timestamps it expects to be read out; a monitor on the falling
// edge pops and compares them whenever a read handshake is presented. Flags
// and counters are compared directly after the edge that updates them.
// Build with SPIKE_RATE_EN defined to include the rate window sequence.
module tb_spike_event_fifo;

    logic       clk;
    logic       reset;
    logic       step;
    logic       spike;
    logic       clear_status;
    logic       full;
    logic       overflow;
    logic [3:0] drop_count;
    logic [7:0] step_count;
`ifdef SPIKE_RATE_EN
    logic [7:0] rate;
`endif

    int total;
    int bad;
    logic [7:0] sb[$];

    spike_event_fifo_if bus ();

    spike_event_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .step         (step),
        .spike        (spike),
        .clear_status (clear_status),
        .rd           (bus),
        .full         (full),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .step_count   (step_count)
`ifdef SPIKE_RATE_EN
        ,
        .rate         (rate)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: a handshake seen on the falling edge completes on the next
    // rising edge, so the presented head must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rd_valid && bus.rd_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL pop_unexpected: got rd_data=%0d, expected no entry", bus.rd_data);
                end else begin
                    logic [7:0] exp_ts;
                    exp_ts = sb.pop_front();
                    if (bus.rd_data !== exp_ts) begin
                        bad++;
                        $display("[TB] FAIL pop_data: got %0d, expected %0d", bus.rd_data, exp_ts);
                    end
                end
            end else if (!bus.rd_valid) begin
                total++;
                if (bus.rd_data !== 8'd0) begin
                    bad++;
                    $display("[TB] FAIL rd_data_empty: got %0d, expected 0", bus.rd_data);
                end
            end
        end
    end

    // Drive one cycle of inputs (called 1ns after a rising edge) and return
    // 1ns after the edge that consumed them.
    task automatic apply_stimulus(input logic st, input logic sp, input logic rr, input logic cs);
        step         = st;
        spike        = sp;
        bus.rd_ready = rr;
        clear_status = cs;
        @(posedge clk);
        #1;
        step         = 1'b0;
        spike        = 1'b0;
        bus.rd_ready = 1'b0;
        clear_status = 1'b0;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        step         = 1'b0;
        spike        = 1'b0;
        bus.rd_ready = 1'b0;
        clear_status = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        step         = 1'b0;
        spike        = 1'b0;
        bus.rd_ready = 1'b0;
        clear_status = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_step_count", step_count, 0);
        check_output("rst_rd_valid", bus.rd_valid, 0);
        check_output("rst_rd_data", bus.rd_data, 0);
        check_output("rst_full", full, 0);
        check_output("rst_overflow", overflow, 0);
        check_output("rst_drop_count", drop_count, 0);
        reset = 1'b0;

        // Spikes at steps 0 and 2
        sb.push_back(8'd0);
        apply_stimulus(1, 1, 0, 0);
        check_output("first_push_valid", bus.rd_valid, 1);
        check_output("first_push_data", bus.rd_data, 0);
        apply_stimulus(1, 0, 0, 0);
        sb.push_back(8'd2);
        apply_stimulus(1, 1, 0, 0);
        check_output("step_count_3", step_count, 3);
        apply_stimulus(0, 0, 1, 0);
        apply_stimulus(0, 0, 1, 0);
        check_output("drained_valid", bus.rd_valid, 0);
        check_output("drained_data", bus.rd_data, 0);

        // Advance to step 10, then six spikes: 14 and 15 are dropped
        repeat (7) apply_stimulus(1, 0, 0, 0);
        check_output("step_count_10", step_count, 10);
        for (int i = 10; i < 16; i++) begin
            if (i < 14) sb.push_back(i[7:0]);
            apply_stimulus(1, 1, 0, 0);
        end
        check_output("burst_full", full, 1);
        check_output("burst_overflow", overflow, 1);
        check_output("burst_drop_count", drop_count, 2);
        check_output("burst_step_count", step_count, 16);

        // Full with push and pop together: head 10 leaves, 16 appended
        sb.push_back(8'd16);
        apply_stimulus(1, 1, 1, 0);
        check_output("pushpop_full", full, 1);
        check_output("pushpop_overflow", overflow, 1);
        check_output("pushpop_drop_count", drop_count, 2);
        check_output("pushpop_head", bus.rd_data, 11);

        // clear_status with a simultaneous drop: the drop wins
        apply_stimulus(1, 1, 0, 1);
        check_output("clr_drop_overflow", overflow, 1);
        check_output("clr_drop_count", drop_count, 1);
        apply_stimulus(0, 0, 0, 1);
        check_output("clr_overflow", overflow, 0);
        check_output("clr_drop_count_0", drop_count, 0);

        // Drain 11,12,13,16 then rd_ready while empty
        repeat (4) apply_stimulus(0, 0, 1, 0);
        apply_stimulus(0, 0, 1, 0);
        check_output("empty_ready_valid", bus.rd_valid, 0);
        check_output("step_count_18", step_count, 18);

        // Push into an empty FIFO while rd_ready is high: no pop
        sb.push_back(8'd18);
        apply_stimulus(1, 1, 1, 0);
        check_output("empty_push_valid", bus.rd_valid, 1);
        check_output("empty_push_data", bus.rd_data, 18);
        apply_stimulus(0, 0, 1, 0);

        // Fill with 19..22 then 16 drops: drop_count saturates at 15
        for (int i = 19; i < 23; i++) begin
            sb.push_back(i[7:0]);
            apply_stimulus(1, 1, 0, 0);
        end
        repeat (16) apply_stimulus(1, 1, 0, 0);
        check_output("sat_drop_count", drop_count, 15);
        check_output("sat_step_count", step_count, 39);
        repeat (4) apply_stimulus(0, 0, 1, 0);

        // Two entries queued, then reset clears everything
        apply_stimulus(1, 1, 0, 0);
        apply_stimulus(1, 1, 0, 0);
        check_output("pre_reset_valid", bus.rd_valid, 1);
        check_output("pre_reset_overflow", overflow, 1);
        do_reset();
        check_output("mid_reset_valid", bus.rd_valid, 0);
        check_output("mid_reset_step_count", step_count, 0);
        check_output("mid_reset_overflow", overflow, 0);
        check_output("mid_reset_drop_count", drop_count, 0);

        // spike without step is ignored
        apply_stimulus(0, 1, 0, 0);
        check_output("nostep_valid", bus.rd_valid, 0);
        check_output("nostep_step_count", step_count, 0);

        // Counter wrap: 256 silent steps land back on 0
        repeat (255) apply_stimulus(1, 0, 0, 0);
        check_output("step_count_255", step_count, 255);
        apply_stimulus(1, 0, 0, 0);
        check_output("step_count_wrap", step_count, 0);
        sb.push_back(8'd0);
        apply_stimulus(1, 1, 0, 0);
        check_output("wrap_ts_data", bus.rd_data, 0);
        check_output("wrap_ts_valid", bus.rd_valid, 1);
        apply_stimulus(0, 0, 1, 0);

`ifdef SPIKE_RATE_EN
        // 16-step window with spikes on every other step, then a silent window
        do_reset();
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1, (i % 2) == 0, 0, 0);
            if (i == 14) check_output("rate_before_close", rate, 0);
        end
        check_output("rate_half", rate, 8);
        repeat (16) apply_stimulus(1, 0, 0, 0);
        check_output("rate_zero", rate, 0);
        do_reset();
`endif

        apply_stimulus(0, 0, 0, 0);
        check_output("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
